// File: rtl/cla_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder sequencer.
package cla_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble index width; kept at 1 bit minimum so WIDTH=4 still has a legal register.
    function automatic int nib_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_ctrl_if.sv
// Operand/result handshake bundle; the sub bit exists only when CLA_SEQ_SUB_EN is defined.
interface cla_seq_ctrl_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef CLA_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef CLA_SEQ_SUB_EN
    modport master (output in_valid, a, b, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/cla_seq_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; exposes c3 so the caller can derive signed overflow.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/cla_seq_ctrl.sv
// Adds WIDTH-bit operands one nibble per cycle on a shared CLA slice; result valid NIB+1 cycles after accept.
// One op in flight, in_ready only in IDLE, result held until out_ready. CLA_SEQ_SUB_EN adds the sub (A-B) option.
module cla_seq_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    cla_seq_ctrl_if.slave bus
);
    localparam int NIB   = WIDTH / SLICE_W;
    localparam int NIB_W = nib_w(NIB);
    localparam logic [NIB_W-1:0] LAST_IDX = NIB_W'(NIB - 1);

    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
        $error("cla_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;
    logic                cout_q;
    logic                ovf_q;
    logic [NIB_W-1:0]    idx_q;
    logic [SLICE_W-1:0]  nib_a;
    logic [SLICE_W-1:0]  nib_b;
    logic [SLICE_W-1:0]  nib_s;
    logic                c3;
    logic                c4;
    logic                in_ready;
    logic                out_valid;
    logic                accept;
    logic                last;

    assign nib_a  = a_q[idx_q*SLICE_W +: SLICE_W];
    assign nib_b  = b_q[idx_q*SLICE_W +: SLICE_W];
    assign last   = (idx_q == LAST_IDX);
    assign accept = in_ready & bus.in_valid;

    cla4_slice u_slice (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_q),
        .s   (nib_s),
        .c3  (c3),
        .c4  (c4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q   <= bus.a;
            idx_q <= '0;
`ifdef CLA_SEQ_SUB_EN
            // Subtract as A + ~B + 1: invert at capture, seed the carry chain with 1.
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
`else
            b_q     <= bus.b;
            carry_q <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            sum_q[idx_q*SLICE_W +: SLICE_W] <= nib_s;
            carry_q <= c4;
            if (last) begin
                cout_q <= c4;
                ovf_q  <= c3 ^ c4;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl (WIDTH=16); expected results are queued at launch and popped at out_valid.
module tb_cla_seq_ctrl;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;
    exp_t sb_q[$];

    cla_seq_ctrl_if #(.WIDTH(16)) bus ();

    cla_seq_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one operand pair in IDLE and consumes the accept edge.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic sb);
        logic [15:0] bb;
        logic [16:0] res;
        exp_t        e;
        bb  = sb ? ~bv : bv;
        res = {1'b0, av} + {1'b0, bb} + {16'd0, sb};
        e.sum  = res[15:0];
        e.cout = res[16];
        e.ovf  = (av[15] == bb[15]) && (res[15] != av[15]);
        sb_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
`ifdef CLA_SEQ_SUB_EN
        bus.sub      = sb;
`endif
        step();
        bus.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, checks latency from the accept edge and the result.
    task automatic wait_done(input string tag);
        int   edges;
        exp_t e;
        edges = 1;
        while (!bus.out_valid && edges < 30) begin
            step();
            edges++;
        end
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_latency"}, edges, 32'd5);
        if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_size"}, sb_q.size(), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check({tag, "_sum"},  {16'd0, bus.sum},  {16'd0, e.sum});
                check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, e.cout});
                check({tag, "_ovf"},  {31'd0, bus.ovf},  {31'd0, e.ovf});
            end
        end
    endtask

    // With out_ready=1 the result lasts one cycle and the block returns to IDLE.
    task automatic drain_one(input string tag);
        step();
        check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_idle"},       {31'd0, bus.in_ready},  32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
`ifdef CLA_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (3) step();
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_sum",       {16'd0, bus.sum},       32'd0);
        check("rst_cout",      {31'd0, bus.cout},      32'd0);
        check("rst_ovf",       {31'd0, bus.ovf},       32'd0);
        rst_n = 1'b1;
        step();

        launch(16'h1234, 16'h4321, 1'b0);
        wait_done("add_5555");
        drain_one("add_5555");

        launch(16'hFFFF, 16'h0001, 1'b0);
        wait_done("carry_ripple");
        drain_one("carry_ripple");

        launch(16'h7FFF, 16'h0001, 1'b0);
        wait_done("signed_ovf");
        drain_one("signed_ovf");

        launch(16'h8000, 16'h8000, 1'b0);
        wait_done("neg_ovf");
        drain_one("neg_ovf");

        // Backpressure, with junk operands offered while busy that must be ignored.
        bus.out_ready = 1'b0;
        launch(16'h1111, 16'h2222, 1'b0);
        bus.in_valid = 1'b1;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        wait_done("bp");
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, bus.in_ready},  32'd0);
            check("bp_hold_sum",   {16'd0, bus.sum},       32'h3333);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain_one("bp");
        step();
        check("bp_no_ghost_op", {31'd0, bus.out_valid}, 32'd0);

        // Reset pulse while the third nibble is being added.
        launch(16'h00FF, 16'h0F0F, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("midrst_sum",       {16'd0, bus.sum},       32'd0);
        check("midrst_cout",      {31'd0, bus.cout},      32'd0);
        sb_q.delete();
        #2;
        rst_n = 1'b1;
        step();
        launch(16'h0002, 16'h0003, 1'b0);
        wait_done("post_rst");
        drain_one("post_rst");

`ifdef CLA_SEQ_SUB_EN
        launch(16'h0005, 16'h0007, 1'b1);
        wait_done("sub_neg");
        drain_one("sub_neg");
        launch(16'h8000, 16'h0001, 1'b1);
        wait_done("sub_ovf");
        drain_one("sub_ovf");
`endif

        for (int i = 0; i < 4; i++) begin
            launch(16'($urandom), 16'($urandom), 1'b0);
            wait_done("rand");
            drain_one("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
